stage_ex_iterative: RTL
=======================

// Module: stage_ex_iterative
// PURPOSE
//  Parametrised execute stage. Single-cycle logic, shift and add/sub/compare results
//  go to the EX/MEM pipeline register combinationally.
//  Adds an iterative multiply/divide engine that writes HI/LO and stalls the
//  pipeline while it runs. Sits between ID/EX and EX/MEM; the stall feeds the hazard unit.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must be a power of two, >= 8
//  SHAMT_W     $clog2(DATA_WIDTH)  localparam, not overridable; shift-amount bits taken from operand_a
// PORTS
//  clock                      in   1           rising-edge clock
//  reset                      in   1           reset, synchronous, active-high
//  flush                      in   1           abort in-flight instruction (exception/redirect)
//  valid                      in   1           ID/EX holds a real instruction
//  operator                   in   8           OPERATOR_* code
//  category                   in   3           CATEGORY_* code
//  operand_a                  in   DATA_WIDTH  rs value / shift amount
//  operand_b                  in   DATA_WIDTH  rt value / immediate
//  register_write_enable_     in   1           from decode
//  register_write_address_    in   5           from decode
//  register_write_enable      out  1           pass-through
//  register_write_address     out  5           pass-through
//  register_write_data        out  DATA_WIDTH  selected result
//  overflow                   out  1           signed overflow on ADD/SUB (trap request)
//  stall_request              out  1           hold ID/EX and earlier stages
//  hilo_write_enable          out  1           one-cycle HI/LO write strobe
//  hi_data                    out  DATA_WIDTH  HI result (remainder / product upper half)
//  lo_data                    out  DATA_WIDTH  LO result (quotient / product lower half)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0. stall_request, hilo_write_enable, hi_data, lo_data,
//    overflow and register_write_data all 0 in the reset cycle.
//  - LOGIC AND/OR/XOR/NOR; SHIFT SLL/SRL/SRA by operand_a[SHAMT_W-1:0] (SRA sign-fills).
//  - ARITH ADD/ADDU/SUB/SUBU/SLT/SLTU: DATA_WIDTH-bit wrap result. overflow=1 only for
//    ADD/SUB on signed overflow; register_write_data still carries the wrapped sum.
//  - SLT/SLTU: result 1 or 0, zero-extended.
//  - Unknown category/operator: register_write_data = 0. All single-cycle paths are
//    combinational, zero latency.
//  - MULDIV (MULT/MULTU/DIV/DIVU): FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE:  issue = valid & category==MULDIV & !flush. On issue: latch operand
//           magnitudes and sign flags, counter=0, go to BUSY.
//    BUSY:  one bit per cycle (shift-add multiply / restoring divide).
//           After DATA_WIDTH iterations go to DONE.
//    DONE:  hi_data/lo_data valid, hilo_write_enable=1 for exactly this cycle, then IDLE.
//           No re-issue from DONE: the same instruction is still at the inputs.
//  - stall_request = (IDLE & issue) | BUSY; low in DONE. For issue at cycle t,
//    stall is high for DATA_WIDTH+1 cycles and DONE falls at t+DATA_WIDTH+1.
//  - Signed ops: magnitudes are used, then negated at the end.
//    Product is negated if the signs differ. Quotient is negated if the signs differ.
//    Remainder takes the sign of the dividend.
//  - Divide by zero: lo = all ones, hi = dividend; no trap.
//  - MIN / -1: lo = MIN, hi = 0.
//  - flush (any state): next state IDLE; stall_request=0 and hilo_write_enable=0 in the
//    flush cycle; no HI/LO write for the aborted op. Reset mid-op behaves the same way.
//  - hi_data/lo_data hold their last values outside DONE. Only hilo_write_enable
//    qualifies them.
//  - A MULDIV instruction passes register_write_enable_ through unchanged
//    (decode drives it 0).
// STRUCTURE
//  - Shared package: OPERATOR_* codes (existing + ADD/ADDU/SUB/SUBU/SLT/SLTU/MULT/MULTU/
//    DIV/DIVU), CATEGORY_* (LOGIC, SHIFT, ARITH, MULDIV) and the MULDIV FSM state encodings.
//  - One sub-module, muldiv_iterative: holds the FSM, counter and datapath.
//    Interface: start, signed, is_div, a, b, flush; outputs busy, done, hi, lo.
//    Result muxing stays in the top module.
// TESTING (DATA_WIDTH=32)
//  - AND 0xF0F01234,0x0FF0FFFF -> 0x00F01234; SRA 0x80000000 by 4 -> 0xF8000000;
//    SRL same -> 0x08000000.
//  - ADD 0x7FFFFFFF+1 -> data 0x80000000, overflow=1; ADDU same -> overflow=0;
//    SLT -1,1 -> 1; SLTU -1,1 -> 0.
//  - MULT -3*5 -> stall 33 cycles, then one hilo_write_enable cycle with
//    HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  - MULTU 0xFFFFFFFF^2 -> HI=0xFFFFFFFE, LO=0x00000001.
//  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7;
//    DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  - flush at iteration 10 of DIV -> stall low that cycle, no hilo_write_enable; a following
//    MULT 6*7 completes with LO=42, HI=0. Repeat the case with reset instead of flush.

Source files
------------

// File: rtl/stage_ex_iterative_pkg.sv
// Shared decode constants for the execute stage: operator/category codes and the
// multiply/divide FSM state encoding.
package stage_ex_iterative_pkg;

    localparam logic [2:0] CATEGORY_NONE   = 3'd0;
    localparam logic [2:0] CATEGORY_LOGIC  = 3'd1;
    localparam logic [2:0] CATEGORY_SHIFT  = 3'd2;
    localparam logic [2:0] CATEGORY_ARITH  = 3'd3;
    localparam logic [2:0] CATEGORY_MULDIV = 3'd4;

    localparam logic [7:0] OPERATOR_AND   = 8'h01;
    localparam logic [7:0] OPERATOR_OR    = 8'h02;
    localparam logic [7:0] OPERATOR_XOR   = 8'h03;
    localparam logic [7:0] OPERATOR_NOR   = 8'h04;
    localparam logic [7:0] OPERATOR_SLL   = 8'h10;
    localparam logic [7:0] OPERATOR_SRL   = 8'h11;
    localparam logic [7:0] OPERATOR_SRA   = 8'h12;
    localparam logic [7:0] OPERATOR_ADD   = 8'h20;
    localparam logic [7:0] OPERATOR_ADDU  = 8'h21;
    localparam logic [7:0] OPERATOR_SUB   = 8'h22;
    localparam logic [7:0] OPERATOR_SUBU  = 8'h23;
    localparam logic [7:0] OPERATOR_SLT   = 8'h24;
    localparam logic [7:0] OPERATOR_SLTU  = 8'h25;
    localparam logic [7:0] OPERATOR_MULT  = 8'h30;
    localparam logic [7:0] OPERATOR_MULTU = 8'h31;
    localparam logic [7:0] OPERATOR_DIV   = 8'h32;
    localparam logic [7:0] OPERATOR_DIVU  = 8'h33;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_BUSY = 2'd1,
        MULDIV_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/stage_ex_iterative_muldiv.sv
// Iterative one-bit-per-cycle multiply (shift-add) and restoring divide engine.
// Works on operand magnitudes and applies sign correction on the last iteration.
module muldiv_iterative
    import stage_ex_iterative_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    muldiv_state_t           state_r;
    logic [CNT_W-1:0]        count_r;
    logic [DATA_WIDTH-1:0]   work_hi_r, work_lo_r, operand_r, dividend_r, hi_r, lo_r;
    logic                    is_div_r, neg_result_r, neg_rem_r, div_zero_r;

    logic [DATA_WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [DATA_WIDTH-1:0]   next_hi_s, next_lo_s, fin_hi_s, fin_lo_s;
    logic [2*DATA_WIDTH-1:0] prod_abs_s, prod_fix_s;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] value,
                                                        input logic             signed_op);
        if (signed_op && value[DATA_WIDTH-1]) begin
            return -value;
        end else begin
            return value;
        end
    endfunction

    // One iteration step for both engines; borrow out of the W+1-bit difference means "restore".
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, operand_r} : {(DATA_WIDTH+1){1'b0}});
        div_shift_s = {work_hi_r, work_lo_r[DATA_WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, operand_r};
        if (is_div_r) begin
            if (!div_diff_s[DATA_WIDTH]) begin
                next_hi_s = div_diff_s[DATA_WIDTH-1:0];
                next_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                next_hi_s = div_shift_s[DATA_WIDTH-1:0];
                next_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi_s = mul_sum_s[DATA_WIDTH:1];
            next_lo_s = {mul_sum_s[0], work_lo_r[DATA_WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied to the final iteration result.
    always_comb begin
        prod_abs_s = {next_hi_s, next_lo_s};
        prod_fix_s = neg_result_r ? -prod_abs_s : prod_abs_s;
        if (!is_div_r) begin
            fin_hi_s = prod_fix_s[2*DATA_WIDTH-1:DATA_WIDTH];
            fin_lo_s = prod_fix_s[DATA_WIDTH-1:0];
        end else if (div_zero_r) begin
            fin_hi_s = dividend_r;
            fin_lo_s = {DATA_WIDTH{1'b1}};
        end else begin
            fin_hi_s = neg_rem_r ? -next_hi_s : next_hi_s;
            fin_lo_s = neg_result_r ? -next_lo_s : next_lo_s;
        end
    end

    // Engine FSM: IDLE -> BUSY (DATA_WIDTH iterations) -> DONE -> IDLE; flush aborts from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= MULDIV_IDLE;
            count_r      <= {CNT_W{1'b0}};
            work_hi_r    <= {DATA_WIDTH{1'b0}};
            work_lo_r    <= {DATA_WIDTH{1'b0}};
            operand_r    <= {DATA_WIDTH{1'b0}};
            dividend_r   <= {DATA_WIDTH{1'b0}};
            hi_r         <= {DATA_WIDTH{1'b0}};
            lo_r         <= {DATA_WIDTH{1'b0}};
            is_div_r     <= 1'b0;
            neg_result_r <= 1'b0;
            neg_rem_r    <= 1'b0;
            div_zero_r   <= 1'b0;
        end else if (flush) begin
            state_r <= MULDIV_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                MULDIV_IDLE: begin
                    if (start) begin
                        state_r      <= MULDIV_BUSY;
                        count_r      <= {CNT_W{1'b0}};
                        work_hi_r    <= {DATA_WIDTH{1'b0}};
                        work_lo_r    <= magnitude(a, is_signed);
                        operand_r    <= magnitude(b, is_signed);
                        dividend_r   <= a;
                        is_div_r     <= is_div;
                        neg_result_r <= is_signed & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
                        neg_rem_r    <= is_signed & a[DATA_WIDTH-1];
                        div_zero_r   <= (b == {DATA_WIDTH{1'b0}});
                    end else begin
                        state_r <= MULDIV_IDLE;
                    end
                end
                MULDIV_BUSY: begin
                    work_hi_r <= next_hi_s;
                    work_lo_r <= next_lo_s;
                    count_r   <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(DATA_WIDTH - 1)) begin
                        hi_r    <= fin_hi_s;
                        lo_r    <= fin_lo_s;
                        state_r <= MULDIV_DONE;
                    end else begin
                        state_r <= MULDIV_BUSY;
                    end
                end
                MULDIV_DONE: state_r <= MULDIV_IDLE;
                default:     state_r <= MULDIV_IDLE;
            endcase
        end
    end

    assign busy = (state_r == MULDIV_BUSY);
    assign done = (state_r == MULDIV_DONE) & ~flush;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/stage_ex_iterative.sv
// Execute stage: combinational logic/shift/arith results plus an iterative
// multiply/divide engine that writes HI/LO and stalls the front of the pipe.
module stage_ex_iterative
    import stage_ex_iterative_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid,
    input  logic [7:0]            operator,
    input  logic [2:0]            category,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  register_write_enable_,
    input  logic [4:0]            register_write_address_,
    output logic                  register_write_enable,
    output logic [4:0]            register_write_address,
    output logic [DATA_WIDTH-1:0] register_write_data,
    output logic                  overflow,
    output logic                  stall_request,
    output logic                  hilo_write_enable,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic [DATA_WIDTH-1:0] lo_data
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  issue_s, md_signed_s, md_div_s, md_busy_s, md_done_s;
    logic [DATA_WIDTH-1:0] md_hi_s, md_lo_s, result_s, sum_s, diff_s;
    logic [SHAMT_W-1:0]    shamt_s;
    logic                  ovf_s;

    assign issue_s     = valid & (category == CATEGORY_MULDIV) & ~flush & ~reset;
    assign md_signed_s = (operator == OPERATOR_MULT) | (operator == OPERATOR_DIV);
    assign md_div_s    = (operator == OPERATOR_DIV)  | (operator == OPERATOR_DIVU);
    assign shamt_s     = operand_a[SHAMT_W-1:0];
    assign sum_s       = operand_a + operand_b;
    assign diff_s      = operand_a - operand_b;

    muldiv_iterative #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .start     (issue_s),
        .is_signed (md_signed_s),
        .is_div    (md_div_s),
        .a         (operand_a),
        .b         (operand_b),
        .busy      (md_busy_s),
        .done      (md_done_s),
        .hi        (md_hi_s),
        .lo        (md_lo_s)
    );

    // Single-cycle result select; anything not decoded yields zero.
    always_comb begin
        result_s = {DATA_WIDTH{1'b0}};
        ovf_s    = 1'b0;
        case (category)
            CATEGORY_LOGIC: begin
                case (operator)
                    OPERATOR_AND: result_s = operand_a & operand_b;
                    OPERATOR_OR:  result_s = operand_a | operand_b;
                    OPERATOR_XOR: result_s = operand_a ^ operand_b;
                    OPERATOR_NOR: result_s = ~(operand_a | operand_b);
                    default:      result_s = {DATA_WIDTH{1'b0}};
                endcase
            end
            CATEGORY_SHIFT: begin
                case (operator)
                    OPERATOR_SLL: result_s = operand_b << shamt_s;
                    OPERATOR_SRL: result_s = operand_b >> shamt_s;
                    OPERATOR_SRA: result_s = $signed(operand_b) >>> shamt_s;
                    default:      result_s = {DATA_WIDTH{1'b0}};
                endcase
            end
            CATEGORY_ARITH: begin
                case (operator)
                    OPERATOR_ADD: begin
                        result_s = sum_s;
                        ovf_s    = (operand_a[DATA_WIDTH-1] == operand_b[DATA_WIDTH-1]) &
                                   (sum_s[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
                    end
                    OPERATOR_ADDU: result_s = sum_s;
                    OPERATOR_SUB: begin
                        result_s = diff_s;
                        ovf_s    = (operand_a[DATA_WIDTH-1] != operand_b[DATA_WIDTH-1]) &
                                   (diff_s[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1]);
                    end
                    OPERATOR_SUBU: result_s = diff_s;
                    OPERATOR_SLT:  result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
                    OPERATOR_SLTU: result_s = {{(DATA_WIDTH-1){1'b0}}, (operand_a < operand_b)};
                    default:       result_s = {DATA_WIDTH{1'b0}};
                endcase
            end
            default: begin
                result_s = {DATA_WIDTH{1'b0}};
                ovf_s    = 1'b0;
            end
        endcase
    end

    assign register_write_enable  = register_write_enable_;
    assign register_write_address = register_write_address_;
    assign register_write_data    = reset ? {DATA_WIDTH{1'b0}} : result_s;
    assign overflow               = ~reset & ovf_s;
    // The issue cycle stalls too, so ID/EX holds the instruction until DONE.
    assign stall_request          = ~reset & ((issue_s & ~md_busy_s & ~md_done_s) | (md_busy_s & ~flush));
    assign hilo_write_enable      = ~reset & md_done_s;
    assign hi_data                = reset ? {DATA_WIDTH{1'b0}} : md_hi_s;
    assign lo_data                = reset ? {DATA_WIDTH{1'b0}} : md_lo_s;

endmodule
